// File: rtl/mem_req_queue.sv
// In-order read/write request queue feeding a registered-read memory port.
// Optional macro MEM_REQ_QUEUE_BYPASS_EN lets a request skip an empty FIFO and issue one cycle earlier.
`timescale 1ns/1ps
module mem_req_queue #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [DATA_W-1:0]        req_data,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_data,
  input  logic                     rsp_ready,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              r_fifo_we   [DEPTH];
  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_rd_pending;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_data;

  logic w_req_ready;
  logic w_rd_busy;
  logic w_fifo_issue;
  logic w_bypass;
  logic w_push;

  // A read may only issue once the previous read has fully left the pipe and its response is free.
  assign w_req_ready  = (r_count != CNT_W'(DEPTH));
  assign w_rd_busy    = (r_mem_en && !r_mem_we) || r_rd_pending || (r_rsp_valid && !rsp_ready);
  assign w_fifo_issue = (r_count != CNT_W'(0)) && (r_fifo_we[r_rd_ptr] || !w_rd_busy);
`ifdef MEM_REQ_QUEUE_BYPASS_EN
  assign w_bypass     = (r_count == CNT_W'(0)) && req_valid && (req_write || !w_rd_busy);
`else
  assign w_bypass     = 1'b0;
`endif
  assign w_push       = req_valid && w_req_ready && !w_bypass;

  assign req_ready = w_req_ready;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign count     = r_count;

  // Entry storage needs no reset: occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_we[r_wr_ptr]   <= req_write;
      r_fifo_addr[r_wr_ptr] <= req_addr;
      r_fifo_data[r_wr_ptr] <= req_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= PTR_W'(0);
      r_rd_ptr     <= PTR_W'(0);
      r_count      <= CNT_W'(0);
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= ADDR_W'(0);
      r_mem_wdata  <= DATA_W'(0);
      r_rd_pending <= 1'b0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= DATA_W'(0);
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_fifo_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_fifo_issue})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase

      if (w_bypass) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= req_write;
        r_mem_addr  <= req_addr;
        r_mem_wdata <= req_data;
      end else if (w_fifo_issue) begin
        r_mem_en    <= 1'b1;
        r_mem_we    <= r_fifo_we[r_rd_ptr];
        r_mem_addr  <= r_fifo_addr[r_rd_ptr];
        r_mem_wdata <= r_fifo_data[r_rd_ptr];
      end else begin
        r_mem_en    <= 1'b0;
      end

      // Read data is valid the cycle after the read strobe; capture wins over consumption.
      r_rd_pending <= r_mem_en && !r_mem_we;
      if (r_rd_pending) begin
        r_rsp_data  <= mem_rdata;
        r_rsp_valid <= 1'b1;
      end else if (rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end else begin
        r_rsp_valid <= r_rsp_valid;
      end
    end
  end
endmodule

// File: tb/tb_mem_req_queue.sv
// Scoreboard bench for mem_req_queue: driver queues expected accesses/responses, a monitor checks them.
`timescale 1ns/1ps
module tb_mem_req_queue;
`ifdef MEM_REQ_QUEUE_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [3:0] req_addr = 4'd0;
  logic [7:0] req_data = 8'd0;
  logic       mem_en, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'd0;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_ready;
  logic [2:0] count;

  mem_req_queue #(.ADDR_W(4), .DATA_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  // Memory with registered read data, as seen by the DUT
  logic [7:0] tmem [16] = '{default: 8'h00};
  always @(posedge clk) begin
    if (mem_en && mem_we) tmem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= tmem[mem_addr];
  end

  int errors = 0;
  int checks = 0;
  int n_mem  = 0;
  int rdy_mode = 1;
  logic [12:0] exp_mem[$];
  logic [7:0]  exp_rsp[$];
  logic [7:0]  shadow [16] = '{default: 8'h00};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'b0;
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: memory accesses and responses against the scoreboard queues
  initial begin
    logic       hold_r;
    logic [7:0] hold_d;
    logic [12:0] e;
    hold_r = 1'b0;
    hold_d = 8'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_r = 1'b0;
      end else begin
        if (mem_en) begin
          n_mem++;
          if (exp_mem.size() == 0) begin
            chk("mem_unexpected", 32'(1), 32'(0));
          end else begin
            e = exp_mem.pop_front();
            chk("mem_we", 32'(mem_we), 32'(e[12]));
            chk("mem_addr", 32'(mem_addr), 32'(e[11:8]));
            if (e[12]) chk("mem_wdata", 32'(mem_wdata), 32'(e[7:0]));
          end
        end
        if (hold_r) begin
          chk("rsp_hold_valid", 32'(rsp_valid), 32'(1));
          chk("rsp_hold_data", 32'(rsp_data), 32'(hold_d));
        end
        if (rsp_valid && rsp_ready) begin
          if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'(1), 32'(0));
          else chk("rsp_data", 32'(rsp_data), 32'(exp_rsp.pop_front()));
        end
        hold_r = rsp_valid && !rsp_ready;
        hold_d = rsp_data;
      end
    end
  end

  task automatic push(input logic w, input logic [3:0] a, input logic [7:0] d);
    bit done;
    done = 1'b0;
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (req_ready) begin
        exp_mem.push_back({w, a, d});
        if (w) shadow[a] = d;
        else   exp_rsp.push_back(shadow[a]);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!done) chk("push_timeout", 32'(0), 32'(1));
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 400 && (exp_mem.size() != 0 || exp_rsp.size() != 0 || rsp_valid); k++) begin
      @(posedge clk); #1;
    end
    chk(name, 32'(exp_mem.size() + exp_rsp.size()), 32'(0));
  endtask

  initial begin
    int  base;
    bit  seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_count", 32'(count), 32'(0));
    chk("rst_req_ready", 32'(req_ready), 32'(1));
    chk("rst_mem_en", 32'(mem_en), 32'(0));
    chk("rst_mem_addr", 32'(mem_addr), 32'(0));
    chk("rst_mem_wdata", 32'(mem_wdata), 32'(0));
    chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rst_rsp_data", 32'(rsp_data), 32'(0));
    @(posedge clk); #1;

    // Accept-to-strobe latency from an empty queue
    push(1'b1, 4'd7, 8'h5A);
    chk("lat_edge0_mem_en", 32'(mem_en), 32'(BYP));
    chk("lat_edge0_count", 32'(count), BYP ? 32'(0) : 32'(1));
    @(posedge clk); #1;
    chk("lat_edge1_mem_en", 32'(mem_en), 32'(!BYP));
    wait_drain("lat_drain");

    // Reset while a read strobe is on the port
    push(1'b0, 4'd3, 8'h00);
    seen = mem_en;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(posedge clk); #1;
      seen = mem_en;
    end
    chk("rstmid_issue_seen", 32'(seen), 32'(1));
    @(negedge clk); #1;
    rst = 1'b1;
    exp_rsp.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rstmid_rsp_valid", 32'(rsp_valid), 32'(0));
    chk("rstmid_count", 32'(count), 32'(0));
    chk("rstmid_mem_en", 32'(mem_en), 32'(0));
    repeat (6) @(posedge clk);
    #1 chk("rstmid_no_rsp", 32'(rsp_valid), 32'(0));

    // Write then read the same address
    push(1'b1, 4'd5, 8'hA5);
    push(1'b0, 4'd5, 8'h00);
    wait_drain("wr_rd_drain");

    // Fill with response backpressure, then drain in order
    rdy_mode = 0;
    fork
      begin
        push(1'b0, 4'd0, 8'h00);
        push(1'b0, 4'd1, 8'h00);
        push(1'b1, 4'd2, 8'h11);
        push(1'b1, 4'd3, 8'h22);
        push(1'b0, 4'd4, 8'h00);
        push(1'b0, 4'd5, 8'h00);
      end
      begin
        repeat (8) @(posedge clk);
        #2 base = n_mem;
        repeat (6) @(posedge clk);
        #2;
        chk("fill_count", 32'(count), 32'(4));
        chk("fill_req_ready", 32'(req_ready), 32'(0));
        chk("fill_no_issue", 32'(n_mem - base), 32'(0));
        chk("fill_rsp_held", 32'(rsp_valid), 32'(1));
        rdy_mode = 1;
      end
    join
    wait_drain("fill_drain");

    // Two back-to-back reads with the consumer stalled
    rdy_mode = 0;
    @(posedge clk); #1;
    base = n_mem;
    push(1'b0, 4'd2, 8'h00);
    push(1'b0, 4'd3, 8'h00);
    repeat (10) @(posedge clk);
    #2 chk("bp_single_issue", 32'(n_mem - base), 32'(1));
    rdy_mode = 1;
    wait_drain("bp_drain");

    // Alternating writes/reads across several pointer wraps, random consumer
    rdy_mode = 2;
    for (int i = 0; i < 12; i++) begin
      if ((i % 2) == 0) push(1'b1, 4'((i / 2) * 3), 8'(8'h40 + i));
      else              push(1'b0, 4'(((i - 1) / 2) * 3), 8'h00);
    end
    rdy_mode = 1;
    wait_drain("wrap_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
